// File: rtl/scanner_pkg.sv
// Shared types and constants for the scanner exposure sequencer.
package scanner_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WAIT_ENV = 4'd1,
        SRC_ON   = 4'd2,
        EXPOSE   = 4'd3,
        MOVE     = 4'd4,
        SETTLE   = 4'd5,
        SRC_OFF  = 4'd6,
        DONE     = 4'd7,
        ERROR    = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ENV_TO   = 2'd1;
    localparam logic [1:0] ERR_SRC_TO   = 2'd2;
    localparam logic [1:0] ERR_SRC_LOST = 2'd3;

    // Bits needed to hold (largest wait - 1), since the timer is loaded with N-1.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scanner_exposure_seq_timer.sv
// Loadable down-counter shared by all sequencer waits. A load value is
// visible in the same cycle it is presented, so a state sees N cycles for a load of N-1.
module scanner_seq_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_cur;

    assign w_cur = i_load ? i_load_val : r_count;
    assign o_tc  = (w_cur == {W{1'b0}});

    // Count down to zero and hold there until the next load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= {W{1'b0}};
        end else if (w_cur != {W{1'b0}}) begin
            r_count <= w_cur - W'(1);
        end else begin
            r_count <= w_cur;
        end
    end

endmodule

// File: rtl/scanner_exposure_seq.sv
// Scan engine: brings up the light source, runs NUM_STEPS exposure windows with
// stage moves in between, shuts the source down and reports done or an error code.
module scanner_exposure_seq
    import scanner_pkg::*;
#(
    parameter int NUM_STEPS     = 8,
    parameter int EXPOSE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ENV_TIMEOUT   = 32,
    parameter int SRC_TIMEOUT   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_env_ok,
    input  logic                         i_source_on,
    output logic                         o_cmd_source_active,
    output logic                         o_expose_active,
    output logic                         o_stage_move,
    output logic [$clog2(NUM_STEPS)-1:0] o_step_idx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic [1:0]                   o_err_code
);

    localparam int TW = timer_width(ENV_TIMEOUT, SRC_TIMEOUT, EXPOSE_CYCLES, SETTLE_CYCLES);
    localparam int SW = $clog2(NUM_STEPS);

    localparam logic [TW-1:0] T_ENV = TW'(ENV_TIMEOUT - 1);
    localparam logic [TW-1:0] T_SRC = TW'(SRC_TIMEOUT - 1);
    localparam logic [TW-1:0] T_EXP = TW'(EXPOSE_CYCLES - 1);
    localparam logic [TW-1:0] T_SET = TW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    state_t        r_state;
    logic          r_cmd;
    logic          r_expose;
    logic          r_move;
    logic [SW-1:0] r_step;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_code;
    logic          r_aborted;
    logic          r_tmr_load;
    logic [TW-1:0] r_tmr_val;
    logic          w_tc;
    logic          w_busy_state;

    assign w_busy_state = (r_state != IDLE) && (r_state != ERROR);

    scanner_seq_timer #(.W(TW)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (r_tmr_load),
        .i_load_val (r_tmr_val),
        .o_tc       (w_tc)
    );

    // Sequencer state machine; every transition also reloads the shared timer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cmd      <= 1'b0;
            r_expose   <= 1'b0;
            r_move     <= 1'b0;
            r_step     <= {SW{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= ERR_NONE;
            r_aborted  <= 1'b0;
            r_tmr_load <= 1'b0;
            r_tmr_val  <= {TW{1'b0}};
        end else begin
            r_move     <= 1'b0;
            r_done     <= 1'b0;
            r_tmr_load <= 1'b0;
            if (i_abort && w_busy_state) begin
                r_state    <= SRC_OFF;
                r_cmd      <= 1'b0;
                r_expose   <= 1'b0;
                r_aborted  <= 1'b1;
                r_tmr_load <= 1'b1;
                r_tmr_val  <= T_SRC;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state    <= WAIT_ENV;
                            r_step     <= {SW{1'b0}};
                            r_busy     <= 1'b1;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_ENV;
                        end
                    end
                    WAIT_ENV: begin
                        if (i_env_ok) begin
                            r_state    <= SRC_ON;
                            r_cmd      <= 1'b1;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_SRC;
                        end else if (w_tc) begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_ENV_TO;
                            r_busy  <= 1'b0;
                        end
                    end
                    SRC_ON: begin
                        if (i_source_on) begin
                            r_state    <= EXPOSE;
                            r_expose   <= 1'b1;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_EXP;
                        end else if (w_tc) begin
                            r_state <= ERROR;
                            r_cmd   <= 1'b0;
                            r_err   <= 1'b1;
                            r_code  <= ERR_SRC_TO;
                            r_busy  <= 1'b0;
                        end
                    end
                    EXPOSE, MOVE, SETTLE: begin
                        if (!i_source_on) begin
                            r_state  <= ERROR;
                            r_cmd    <= 1'b0;
                            r_expose <= 1'b0;
                            r_err    <= 1'b1;
                            r_code   <= ERR_SRC_LOST;
                            r_busy   <= 1'b0;
                        end else if (r_state == MOVE) begin
                            r_state    <= SETTLE;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_SET;
                        end else if (w_tc && r_state == SETTLE) begin
                            r_state    <= EXPOSE;
                            r_expose   <= 1'b1;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_EXP;
                        end else if (w_tc && r_step == LAST_STEP) begin
                            r_state    <= SRC_OFF;
                            r_expose   <= 1'b0;
                            r_cmd      <= 1'b0;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_SRC;
                        end else if (w_tc) begin
                            r_state    <= MOVE;
                            r_expose   <= 1'b0;
                            r_move     <= 1'b1;
                            r_step     <= r_step + SW'(1);
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_EXP;
                        end
                    end
                    SRC_OFF: begin
                        if (!i_source_on) begin
                            r_state   <= r_aborted ? IDLE : DONE;
                            r_done    <= !r_aborted;
                            r_busy    <= !r_aborted;
                            r_aborted <= 1'b0;
                        end else if (w_tc) begin
                            r_state   <= ERROR;
                            r_err     <= 1'b1;
                            r_code    <= ERR_SRC_TO;
                            r_busy    <= 1'b0;
                            r_aborted <= 1'b0;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    ERROR: begin
                        r_cmd    <= 1'b0;
                        r_expose <= 1'b0;
                        if (i_start) begin
                            r_state    <= WAIT_ENV;
                            r_err      <= 1'b0;
                            r_code     <= ERR_NONE;
                            r_step     <= {SW{1'b0}};
                            r_busy     <= 1'b1;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= T_ENV;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_cmd    <= 1'b0;
                        r_expose <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cmd_source_active = r_cmd;
    assign o_expose_active     = r_expose;
    assign o_stage_move        = r_move;
    assign o_step_idx          = r_step;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_err               = r_err;
    assign o_err_code          = r_code;

endmodule
